// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Imported by the arbiter and its testbench.
package mem_arb_pkg;

   localparam int MEM_LATENCY_DEF = 4;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties; each access takes MEM_LATENCY busy cycles plus a response.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              halted,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              mem_start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] START_CNT =
      CNT_W'(MEM_LATENCY - 1);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_lat
      $error("MEM_LATENCY must be in 1..15");
   end

   arb_state_t       state_q;
   arb_state_t       state_d;
   arb_owner_t       owner_q;
   logic             we_q;
   logic [CNT_W-1:0] cnt;
   logic             grant;
   logic             grant_d;
   logic             last_busy;

   assign last_busy = (state_q == BUSY) && (cnt == '0);

   // Next-state: requests only considered in IDLE, data first.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      grant_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!halted && (d_req || if_req)) begin
               grant   = 1'b1;
               grant_d = d_req;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the granted request, count busy cycles, capture read data.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         owner_q   <= OWN_IF;
         we_q      <= 1'b0;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant) begin
            owner_q  <= grant_d ? OWN_D : OWN_IF;
            we_q     <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            cnt      <= START_CNT;
            if (grant_d) begin
               mem_wdata <= d_wdata;
            end
         end else if (state_q == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (last_busy && !we_q) begin
            if (owner_q == OWN_D) begin
               d_rdata <= mem_rdata;
            end else begin
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_start = (state_q == BUSY) && (cnt == START_CNT);
   assign mem_we    = (state_q == BUSY) && we_q;
   assign if_done   = (state_q == RESP) && (owner_q == OWN_IF);
   assign d_done    = (state_q == RESP) && (owner_q == OWN_D);
   assign if_stall  = if_req & ~if_done;
   assign d_stall   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents, memory model,
// and a monitor checking accesses, latency and returned data.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int L = 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        halted = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_stall;
   logic        mem_start;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)
   ) dut (
      .clk(clk), .rst_b(rst_b), .halted(halted),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_done(if_done),
      .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_done(d_done), .d_stall(d_stall),
      .mem_start(mem_start), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] init_word(int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h2402_000A;
   endfunction

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: real data only in the last busy cycle.
   int          cyc = 0;
   int          ms_cyc = -100;
   logic [31:0] mem_arr [128];
   bit          written [128];
   logic [6:0]  ridx;
   logic        rd_last;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_start) ms_cyc <= cyc;
      if (mem_start && mem_we) begin
         mem_arr[mem_addr[8:2]] <= mem_wdata;
         written[mem_addr[8:2]] <= 1'b1;
      end
   end

   always_comb begin
      ridx = mem_addr[8:2];
      rd_last = mem_start ? (L == 1) : (cyc == ms_cyc + L - 1);
      if (!rd_last)
         mem_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      else if (written[ridx])
         mem_rdata = mem_arr[ridx];
      else
         mem_rdata = init_word(int'(ridx));
   end

   cmd_t        if_cmd[$];
   cmd_t        d_cmd[$];
   logic [31:0] if_exp[$];
   logic [31:0] d_exp[$];
   bit          if_busy = 0;
   bit          d_busy = 0;
   int          if_raise = 0;
   int          d_raise = 0;
   cmd_t        if_cur = '0;
   cmd_t        d_cur = '0;
   bit          if_started = 0;
   bit          d_started = 0;
   int          n_starts = 0;
   bit          lat_chk = 1;

   // Fetch agent: present commands, scramble inputs once latched.
   initial begin
      logic [31:0] if_last;
      if_last = '0;
      forever begin
         @(posedge clk); #2;
         if (!rst_b) begin
            if_req = 0; if_busy = 0; if_last = '0;
         end else begin
            if (if_done) begin
               if_busy = 0; if_req = 0;
            end
            if (!if_busy && if_cmd.size() > 0) begin
               if_cur = if_cmd.pop_front();
               if_cur.we = 1'b0;
               if_req = 1; if_addr = if_cur.addr;
               if_busy = 1; if_raise = cyc;
               if_last = init_word(int'(if_cur.addr[8:2]));
               if_exp.push_back(if_last);
            end else if (if_busy && if_started) begin
               if_addr = $urandom;
            end
         end
      end
   end

   // Data agent with a reference memory of committed stores.
   initial begin
      logic [31:0] ref_mem [128];
      logic [31:0] d_last;
      logic [6:0]  ix;
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      d_last = '0;
      forever begin
         @(posedge clk); #2;
         if (!rst_b) begin
            d_req = 0; d_busy = 0; d_last = '0;
         end else begin
            if (d_done) begin
               d_busy = 0; d_req = 0;
            end
            if (!d_busy && d_cmd.size() > 0) begin
               d_cur = d_cmd.pop_front();
               d_req = 1; d_we = d_cur.we;
               d_addr = d_cur.addr; d_wdata = d_cur.wdata;
               d_busy = 1; d_raise = cyc;
               ix = d_cur.addr[8:2];
               if (d_cur.we) ref_mem[ix] = d_cur.wdata;
               else d_last = ref_mem[ix];
               d_exp.push_back(d_last);
            end else if (d_busy && d_started) begin
               d_addr = $urandom; d_wdata = $urandom;
               d_we = $urandom_range(0, 1);
            end
         end
      end
   end

   // Monitor: access ownership, latched values, latency, data.
   initial begin
      int   mon_start;
      int   last_done;
      int   raise;
      int   e;
      bit   own_d;
      cmd_t cur;
      mon_start = -100; last_done = -100;
      own_d = 0; cur = '0;
      forever begin
         @(negedge clk);
         if (!rst_b) begin
            if_exp.delete(); d_exp.delete();
            if_started = 0; d_started = 0;
            mon_start = -100;
         end else begin
            chk("if_stall", 32'(if_stall), 32'(if_req & ~if_done));
            chk("d_stall", 32'(d_stall), 32'(d_req & ~d_done));
            if (mem_start) begin
               raise = -1;
               if (d_busy && !d_started && d_raise < cyc) begin
                  own_d = 1; cur = d_cur; raise = d_raise;
                  d_started = 1;
               end else if (if_busy && !if_started &&
                            if_raise < cyc) begin
                  own_d = 0; cur = if_cur; raise = if_raise;
                  if_started = 1;
               end
               if (raise < 0) begin
                  tests++; fails++;
                  $display("FAIL spurious_start: at cycle %0d", cyc);
               end else begin
                  n_starts++;
                  mon_start = cyc;
                  if (lat_chk) begin
                     e = raise;
                     if (last_done + 1 > e) e = last_done + 1;
                     chk("start_cycle", cyc, e + 1);
                  end
               end
            end
            if (cyc >= mon_start && cyc < mon_start + L) begin
               chk("mem_addr", mem_addr, cur.addr);
               chk("mem_we", 32'(mem_we), 32'(cur.we));
               if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
               if (cyc != mon_start)
                  chk("mem_start_once", 32'(mem_start), 0);
            end else begin
               chk("mem_we_idle", 32'(mem_we), 0);
            end
            if (if_done && d_done) begin
               tests++; fails++;
               $display("FAIL both_done: at cycle %0d", cyc);
            end
            if (if_done) begin
               if (own_d || if_exp.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL if_done_unexp: cycle %0d", cyc);
               end else begin
                  chk("if_rdata", if_rdata, if_exp.pop_front());
                  chk("if_lat", cyc, mon_start + L);
               end
               if_started = 0; last_done = cyc;
            end
            if (d_done) begin
               if (!own_d || d_exp.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL d_done_unexp: cycle %0d", cyc);
               end else begin
                  chk("d_rdata", d_rdata, d_exp.pop_front());
                  chk("d_lat", cyc, mon_start + L);
               end
               d_started = 0; last_done = cyc;
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((if_busy || d_busy || if_cmd.size() > 0 ||
              d_cmd.size() > 0) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) begin
         tests++; fails++;
         $display("FAIL idle_timeout: %0d cycles", n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_if_done"}, 32'(if_done), 0);
      chk({tag, "_d_done"}, 32'(d_done), 0);
      chk({tag, "_mem_start"}, 32'(mem_start), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_stalls"}, 32'({if_stall, d_stall}), 0);
   endtask

   function automatic cmd_t rnd_if();
      return '{we: 1'b0, addr: 32'd4 * ($urandom % 64),
               wdata: 32'h0};
   endfunction

   function automatic cmd_t rnd_d();
      return '{we: 1'($urandom_range(0, 1)),
               addr: 32'h100 + 32'd4 * ($urandom % 64),
               wdata: $urandom};
   endfunction

   initial begin
      int n;
      int s;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #2 rst_b = 1;

      if_cmd.push_back('{we: 0, addr: 32'h40, wdata: 0});
      wait_idle();
      d_cmd.push_back('{we: 1, addr: 32'h100,
                        wdata: 32'hDEAD_BEEF});
      wait_idle();
      d_cmd.push_back('{we: 0, addr: 32'h100, wdata: 0});
      wait_idle();
      chk("store_readback", d_rdata, 32'hDEAD_BEEF);

      if_cmd.push_back('{we: 0, addr: 32'h40, wdata: 0});
      if_cmd.push_back('{we: 0, addr: 32'h44, wdata: 0});
      wait_idle();

      d_cmd.push_back('{we: 0, addr: 32'h200 - 32'h4, wdata: 0});
      if_cmd.push_back('{we: 0, addr: 32'h80, wdata: 0});
      wait_idle();

      for (int i = 0; i < 120; i++) begin
         s = int'($urandom % 4);
         if (s[0]) if_cmd.push_back(rnd_if());
         if (s[1]) d_cmd.push_back(rnd_d());
         repeat ($urandom % 5) @(negedge clk);
         n = 0;
         while ((if_cmd.size() > 2 || d_cmd.size() > 2) &&
                n < 200) begin
            @(negedge clk); n++;
         end
      end
      wait_idle();

      lat_chk = 0;
      if_cmd.push_back('{we: 0, addr: 32'h88, wdata: 0});
      if_cmd.push_back('{we: 0, addr: 32'h8C, wdata: 0});
      n = 0;
      while (!if_started && n < 100) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #2 halted = 1;
      repeat (L + 2) @(negedge clk);
      s = n_starts;
      repeat (20) @(negedge clk);
      chk("halt_no_start", n_starts, s);
      chk("halt_pending", 32'(if_exp.size()), 1);
      chk("halt_stall", 32'(if_stall), 1);
      @(posedge clk); #2 halted = 0;
      wait_idle();
      lat_chk = 1;

      d_cmd.push_back('{we: 0, addr: 32'h120, wdata: 0});
      n = 0;
      while (!d_started && n < 100) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #2 rst_b = 0;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("midreset");
      @(posedge clk); #2 rst_b = 1;
      repeat (L + 3) @(negedge clk);
      chk("midreset_no_done", 32'(d_exp.size()), 0);
      d_cmd.push_back('{we: 0, addr: 32'h120, wdata: 0});
      if_cmd.push_back('{we: 0, addr: 32'h10, wdata: 0});
      wait_idle();

      chk("end_if_queue", 32'(if_exp.size()), 0);
      chk("end_d_queue", 32'(d_exp.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
